// File: rtl/time_param_writer.sv
// rtl/time_param_writer.sv - programs one timing parameter into the parameter store with write/verify/retry
//
// Captures a (selector, value) pair on a rising edge of reprogram, writes it to the
// parameter store, reads it back and retries a bounded number of times on mismatch.
// A captured value of zero is replaced by the per-parameter default.
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   reprogram      in   debounced reprogram request (level)
//   time_param_sel in   [1:0] parameter to program
//   time_value     in   [3:0] value to program, seconds (0 = use default)
//   rd_value       in   [3:0] combinational store readback at address wr_sel
//   wr_en          out  one-cycle write strobe to the store
//   wr_sel         out  [1:0] write address, held from WRITE through DONE
//   wr_value       out  [3:0] write data, held from WRITE through DONE
//   busy           out  high in WRITE and VERIFY
//   done           out  one-cycle pulse on a verified write
//   error          out  sticky failure flag, cleared by the next accepted request
//   write_count    out  [3:0] count of verified writes, wraps 15 -> 0

module time_param_writer #(
    parameter int MAX_RETRY  = 2,
    parameter int DEF_ARM    = 6,
    parameter int DEF_DRIVER = 8,
    parameter int DEF_PASS   = 15,
    parameter int DEF_ALARM  = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       reprogram,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    input  logic [3:0] rd_value,
    output logic       wr_en,
    output logic [1:0] wr_sel,
    output logic [3:0] wr_value,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] write_count
);

    localparam logic [3:0] RETRY_MAX  = 4'(MAX_RETRY);
    localparam logic [3:0] DEF_ARM_V  = 4'(DEF_ARM);
    localparam logic [3:0] DEF_DRV_V  = 4'(DEF_DRIVER);
    localparam logic [3:0] DEF_PASS_V = 4'(DEF_PASS);
    localparam logic [3:0] DEF_ALM_V  = 4'(DEF_ALARM);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_VERIFY = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t     state, state_nxt;
    logic       reprogram_q;
    logic       armed;
    logic [3:0] retry_cnt, retry_nxt;

    logic       wr_en_nxt, busy_nxt, done_nxt, error_nxt;
    logic [1:0] wr_sel_nxt;
    logic [3:0] wr_value_nxt, count_nxt;
    logic [3:0] capture_value;
    logic       rise;

    // armed stays low for the first cycle after reset release so that a request
    // already held high at release is seen as a level, not as a new edge.
    assign rise = reprogram & ~reprogram_q & armed;

    always_comb begin
        capture_value = time_value;
        if (time_value == 4'd0) begin
            case (time_param_sel)
                2'b00:   capture_value = DEF_ARM_V;
                2'b01:   capture_value = DEF_DRV_V;
                2'b10:   capture_value = DEF_PASS_V;
                default: capture_value = DEF_ALM_V;
            endcase
        end
    end

    always_comb begin
        state_nxt    = state;
        wr_en_nxt    = 1'b0;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        error_nxt    = error;
        wr_sel_nxt   = wr_sel;
        wr_value_nxt = wr_value;
        count_nxt    = write_count;
        retry_nxt    = retry_cnt;

        case (state)
            S_IDLE, S_ERR: begin
                if (rise) begin
                    wr_sel_nxt   = time_param_sel;
                    wr_value_nxt = capture_value;
                    retry_nxt    = 4'd0;
                    error_nxt    = 1'b0;
                    state_nxt    = S_WRITE;
                    wr_en_nxt    = 1'b1;
                    busy_nxt     = 1'b1;
                end
            end
            S_WRITE: begin
                state_nxt = S_VERIFY;
                busy_nxt  = 1'b1;
            end
            S_VERIFY: begin
                if (rd_value == wr_value) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                    count_nxt = write_count + 4'd1;
                end else if (retry_cnt < RETRY_MAX) begin
                    retry_nxt = retry_cnt + 4'd1;
                    state_nxt = S_WRITE;
                    wr_en_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end else begin
                    state_nxt = S_ERR;
                    error_nxt = 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered copies of the next-state decode, so each strobe
    // appears in the cycle of the state it belongs to.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            reprogram_q <= 1'b0;
            armed       <= 1'b0;
            retry_cnt   <= 4'd0;
            wr_en       <= 1'b0;
            wr_sel      <= 2'd0;
            wr_value    <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            write_count <= 4'd0;
        end else begin
            state       <= state_nxt;
            reprogram_q <= reprogram;
            armed       <= 1'b1;
            retry_cnt   <= retry_nxt;
            wr_en       <= wr_en_nxt;
            wr_sel      <= wr_sel_nxt;
            wr_value    <= wr_value_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            error       <= error_nxt;
            write_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_time_param_writer.sv
// tb/tb_time_param_writer.sv - directed self-checking bench for time_param_writer

module tb_time_param_writer;

    logic       clock = 1'b0;
    logic       reset;
    logic       reprogram;
    logic [1:0] time_param_sel;
    logic [3:0] time_value;
    logic [3:0] rd_value;
    logic       wr_en;
    logic [1:0] wr_sel;
    logic [3:0] wr_value;
    logic       busy;
    logic       done;
    logic       error;
    logic [3:0] write_count;

    logic [3:0] store [4];
    logic       rd_force_zero;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] val;
    } exp_t;
    exp_t sb[$];

    int         errors = 0;
    int         checks = 0;
    logic [3:0] exp_count = 4'd0;
    int         pulses;
    int         dones;
    int         busies;
    logic [7:0] pulse_mask;

    time_param_writer dut (
        .clock          (clock),
        .reset          (reset),
        .reprogram      (reprogram),
        .time_param_sel (time_param_sel),
        .time_value     (time_value),
        .rd_value       (rd_value),
        .wr_en          (wr_en),
        .wr_sel         (wr_sel),
        .wr_value       (wr_value),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .write_count    (write_count)
    );

    always #5 clock = ~clock;

    // Behavioural parameter store with combinational readback.
    always @(posedge clock) begin
        if (wr_en) store[wr_sel] <= wr_value;
    end
    assign rd_value = rd_force_zero ? 4'd0 : store[wr_sel];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One complete request that should verify first time.
    task automatic do_write(input logic [1:0] sel, input logic [3:0] val, input logic [3:0] expv);
        exp_t e;
        time_param_sel = sel;
        time_value     = val;
        reprogram      = 1'b1;
        sb.push_back('{sel: sel, val: expv});
        step();
        check("wr_en_first", {7'd0, wr_en}, 8'd1);
        check("wr_sel", {6'd0, wr_sel}, {6'd0, sel});
        check("wr_value", {4'd0, wr_value}, {4'd0, expv});
        time_param_sel = ~sel;
        time_value     = ~val;
        reprogram      = 1'b0;
        step();
        check("wr_en_verify", {7'd0, wr_en}, 8'd0);
        check("busy_verify", {7'd0, busy}, 8'd1);
        step();
        check("done_pulse", {7'd0, done}, 8'd1);
        exp_count = exp_count + 4'd1;
        if (done && sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_sel", {6'd0, wr_sel}, {6'd0, e.sel});
            check("sb_val", {4'd0, wr_value}, {4'd0, e.val});
        end
        check("write_count", {4'd0, write_count}, {4'd0, exp_count});
        step();
        check("done_drop", {7'd0, done}, 8'd0);
        check("busy_idle", {7'd0, busy}, 8'd0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) store[i] = 4'd0;
        rd_force_zero  = 1'b0;
        reset          = 1'b0;
        reprogram      = 1'b0;
        time_param_sel = 2'd0;
        time_value     = 4'd0;

        // Reset state
        step();
        step();
        check("rst_wr_en", {7'd0, wr_en}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_done", {7'd0, done}, 8'd0);
        check("rst_error", {7'd0, error}, 8'd0);
        check("rst_count", {4'd0, write_count}, 8'd0);
        check("rst_sel_val", {2'd0, wr_sel, wr_value}, 8'd0);
        reset = 1'b1;
        step();
        step();

        // Basic write, sel=01 value=5
        do_write(2'b01, 4'd5, 4'd5);

        // Zero value takes the passenger-door default, single strobe
        pulses = 0;
        time_param_sel = 2'b10;
        time_value     = 4'd0;
        reprogram      = 1'b1;
        sb.push_back('{sel: 2'b10, val: 4'd15});
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 1) begin
                check("def_value", {4'd0, wr_value}, 8'd15);
                reprogram = 1'b0;
            end
            if (wr_en) pulses++;
            if (done) begin
                exp_count = exp_count + 4'd1;
                void'(sb.pop_front());
                check("def_done_cycle", i[7:0], 8'd3);
            end
        end
        check("def_pulses", pulses[7:0], 8'd1);
        check("def_count", {4'd0, write_count}, {4'd0, exp_count});

        // Readback stuck at zero: three strobes two cycles apart, then error
        rd_force_zero = 1'b1;
        pulses = 0;
        dones = 0;
        pulse_mask = 8'd0;
        time_param_sel = 2'b00;
        time_value     = 4'd7;
        reprogram      = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            reprogram = 1'b0;
            if (wr_en) begin
                pulses++;
                pulse_mask[i] = 1'b1;
            end
            if (done) dones++;
        end
        check("retry_pulses", pulses[7:0], 8'd3);
        check("retry_spacing", pulse_mask, 8'b0010_1010);
        check("retry_no_done", dones[7:0], 8'd0);
        check("retry_error", {7'd0, error}, 8'd1);
        check("retry_busy", {7'd0, busy}, 8'd0);
        step();
        step();
        check("error_sticky", {7'd0, error}, 8'd1);
        check("error_no_wr", {7'd0, wr_en}, 8'd0);
        check("count_unchanged", {4'd0, write_count}, {4'd0, exp_count});
        rd_force_zero = 1'b0;
        do_write(2'b11, 4'd9, 4'd9);
        check("error_cleared", {7'd0, error}, 8'd0);

        // Second edge during VERIFY is ignored
        pulses = 0;
        dones = 0;
        time_param_sel = 2'b00;
        time_value     = 4'd3;
        reprogram      = 1'b1;
        sb.push_back('{sel: 2'b00, val: 4'd3});
        step();
        reprogram = 1'b0;
        if (wr_en) pulses++;
        step();
        reprogram = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (wr_en) pulses++;
            if (done) begin
                dones++;
                exp_count = exp_count + 4'd1;
                void'(sb.pop_front());
            end
        end
        check("ignore_pulses", pulses[7:0], 8'd1);
        check("ignore_dones", dones[7:0], 8'd1);
        reprogram = 1'b0;
        step();

        // Fill to 16 verified writes; counter wraps to zero
        while (exp_count != 4'd0) begin
            logic [1:0] s;
            logic [3:0] v;
            s = 2'($urandom_range(0, 3));
            v = 4'($urandom_range(1, 15));
            do_write(s, v, v);
        end
        check("count_wrap", {4'd0, write_count}, 8'd0);

        // Reset mid-WRITE drops strobes immediately; held request is not an edge
        time_param_sel = 2'b01;
        time_value     = 4'd4;
        reprogram      = 1'b1;
        step();
        check("pre_reset_wr_en", {7'd0, wr_en}, 8'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_wr_en", {7'd0, wr_en}, 8'd0);
        check("async_busy", {7'd0, busy}, 8'd0);
        sb.delete();
        exp_count = 4'd0;
        @(posedge clock);
        #3;
        reset = 1'b1;
        pulses = 0;
        busies = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (wr_en) pulses++;
            if (busy) busies++;
        end
        check("held_no_write", pulses[7:0], 8'd0);
        check("held_no_busy", busies[7:0], 8'd0);
        check("post_reset_count", {4'd0, write_count}, {4'd0, exp_count});
        check("sb_empty", 8'(sb.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
